// File: rtl/itlb_pkg.sv
// Shared definitions for the instruction-TLB refill walker: walk states,
// PTE field positions, fault-cause encodings and the PTE address helper.
package itlb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FAULT = 3'd4,
    S_DRAIN = 3'd5
  } walk_state_e;

  localparam int PTE_V_BIT   = 0;
  localparam int PTE_X_BIT   = 1;
  localparam int PTE_PPN_LSB = 8;
  localparam int PTE_PPN_MSB = 15;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_NOEXEC  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // One 4-byte PTE per virtual page; the sum wraps naturally at 32 bits.
  function automatic logic [31:0] pte_addr(input logic [31:0] base,
                                           input logic [19:0] vpn);
    return base + {10'd0, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/itlb_walk_timer.sv
// Response timer for an outstanding page-table read. Counts enabled cycles
// since the last clear; expired flags the last cycle the walker may wait.
module itlb_walk_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // Cycle counter, cleared while no read is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // After TIMEOUT-1 empty cycles, the current cycle is the last one allowed.
  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/itlb_refill_ctrl.sv
// Instruction-TLB refill controller: on an iTLB miss it reads one PTE from
// the page table, then either fills the iTLB or raises a page fault.
module itlb_refill_ctrl
  import itlb_pkg::*;
#(
  parameter logic [31:0] PTBR    = 32'h0001_0000,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        supervisor_mode,
  input  logic        miss_valid,
  input  logic [31:0] miss_vaddr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        tlb_write,
  output logic [19:0] reg_logic_page,
  output logic [7:0]  reg_physical_page,
  output logic        refill_done,
  output logic        busy,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_vaddr
);

  walk_state_e state;
  logic [31:0] vaddr_q;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;
  logic        pte_v;
  logic        pte_x;
  logic [7:0]  pte_ppn;
  logic        unused_pte_bits;

  assign pte_v           = mem_rdata[PTE_V_BIT];
  assign pte_x           = mem_rdata[PTE_X_BIT];
  assign pte_ppn         = mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
  assign unused_pte_bits = ^{mem_rdata[31:16], mem_rdata[7:2]};

  // The timer runs from grant until the response arrives, through DRAIN too.
  assign timer_clear  = (state == S_IDLE) || (state == S_REQ);
  assign timer_enable = ((state == S_WAIT) || (state == S_DRAIN)) && !mem_rvalid;

  itlb_walk_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_walk_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Walk FSM; every output is registered and set alongside its next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      vaddr_q           <= '0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      tlb_write         <= 1'b0;
      refill_done       <= 1'b0;
      reg_logic_page    <= '0;
      reg_physical_page <= '0;
      busy              <= 1'b0;
      fault_valid       <= 1'b0;
      fault_cause       <= CAUSE_NONE;
      fault_vaddr       <= '0;
    end else begin
      mem_req     <= 1'b0;
      tlb_write   <= 1'b0;
      refill_done <= 1'b0;
      fault_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_valid && !supervisor_mode && !flush) begin
            vaddr_q        <= miss_vaddr;
            reg_logic_page <= miss_vaddr[31:12];
            mem_addr       <= pte_addr(PTBR, miss_vaddr[31:12]);
            mem_req        <= 1'b1;
            busy           <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          // A flush beats a same-cycle grant: the read is treated as never issued.
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (mem_gnt) begin
            state <= S_WAIT;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (!pte_v) begin
              fault_valid <= 1'b1;
              fault_cause <= CAUSE_INVALID;
              fault_vaddr <= vaddr_q;
              state       <= S_FAULT;
            end else if (!pte_x) begin
              fault_valid <= 1'b1;
              fault_cause <= CAUSE_NOEXEC;
              fault_vaddr <= vaddr_q;
              state       <= S_FAULT;
            end else begin
              tlb_write         <= 1'b1;
              refill_done       <= 1'b1;
              reg_physical_page <= pte_ppn;
              state             <= S_WRITE;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end else if (timer_expired) begin
            fault_valid <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            fault_vaddr <= vaddr_q;
            state       <= S_FAULT;
          end
        end
        S_WRITE, S_FAULT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_DRAIN: begin
          // Swallow the one read still in flight so it cannot hit a later walk.
          if (mem_rvalid || timer_expired) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: scoreboarded walks plus
// flush, timeout, reset and supervisor scenarios.
module tb_itlb_refill_ctrl;

  localparam logic [31:0] PTBR_TB    = 32'h0001_0000;
  localparam int          TIMEOUT_TB = 64;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        supervisor_mode;
  logic        miss_valid;
  logic [31:0] miss_vaddr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [19:0] reg_logic_page;
  logic [7:0]  reg_physical_page;
  logic        refill_done;
  logic        busy;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_vaddr;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [19:0] vpn;
    logic [7:0]  ppn;
    logic [31:0] vaddr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_write = 0;
  int   n_fault = 0;

  itlb_refill_ctrl #(
    .PTBR   (PTBR_TB),
    .TIMEOUT(TIMEOUT_TB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .supervisor_mode  (supervisor_mode),
    .miss_valid       (miss_valid),
    .miss_vaddr       (miss_vaddr),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .tlb_write        (tlb_write),
    .reg_logic_page   (reg_logic_page),
    .reg_physical_page(reg_physical_page),
    .refill_done      (refill_done),
    .busy             (busy),
    .fault_valid      (fault_valid),
    .fault_cause      (fault_cause),
    .fault_vaddr      (fault_vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tlb_write === 1'b1) n_write++;
    if (fault_valid === 1'b1) n_fault++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one walk given the PTE returned.
  function automatic exp_t model(input logic [31:0] va, input logic [31:0] pte);
    exp_t e;
    e.vpn      = va[31:12];
    e.ppn      = pte[15:8];
    e.vaddr    = va;
    e.is_fault = 1'b1;
    if (pte[0] == 1'b0)      e.cause = 2'b01;
    else if (pte[1] == 1'b0) e.cause = 2'b10;
    else begin
      e.is_fault = 1'b0;
      e.cause    = 2'b00;
    end
    return e;
  endfunction

  task automatic run_walk(input logic [31:0] va, input logic [31:0] pte,
                          input int gdly, input int rdly, output int req_wait);
    exp_t        e;
    int          k;
    logic [31:0] exp_addr;
    exp_addr   = PTBR_TB + {10'd0, va[31:12], 2'b00};
    miss_valid = 1'b1;
    miss_vaddr = va;
    tick();
    k = 0;
    while (mem_req !== 1'b1 && k < 4) begin
      tick();
      k++;
    end
    req_wait = k;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL walk_req: mem_req %b addr %h, expected 1 %h", mem_req, mem_addr, exp_addr);
    end
    miss_vaddr = va ^ 32'hFFFF_F000;
    repeat (gdly) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (rdly) tick();
    sb.push_back(model(va, pte));
    mem_rvalid = 1'b1;
    mem_rdata  = pte;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    k = 0;
    while (!(tlb_write === 1'b1 || fault_valid === 1'b1) && k < 8) begin
      tick();
      k++;
    end
    miss_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL walk_latency: result %0d cycles after rvalid, expected 0", k);
    end
    checks++;
    if (tlb_write !== ~e.is_fault || refill_done !== ~e.is_fault || fault_valid !== e.is_fault) begin
      errors++;
      $display("FAIL walk_kind: write %b done %b fault %b, expected fault=%b",
               tlb_write, refill_done, fault_valid, e.is_fault);
    end
    checks++;
    if (e.is_fault) begin
      if (fault_cause !== e.cause || fault_vaddr !== e.vaddr) begin
        errors++;
        $display("FAIL walk_fault: cause %b vaddr %h, expected %b %h",
                 fault_cause, fault_vaddr, e.cause, e.vaddr);
      end
    end else if (reg_logic_page !== e.vpn || reg_physical_page !== e.ppn) begin
      errors++;
      $display("FAIL walk_fill: vpn %h ppn %h, expected %h %h",
               reg_logic_page, reg_physical_page, e.vpn, e.ppn);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req %b busy %b, expected 0 0", mem_req, busy);
    end
    checks++;
    if ({tlb_write, refill_done, fault_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: %b, expected 000", {tlb_write, refill_done, fault_valid});
    end
    checks++;
    if (mem_addr !== 32'h0 || fault_vaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: mem_addr %h fault_vaddr %h, expected 0 0", mem_addr, fault_vaddr);
    end
    checks++;
    if (reg_logic_page !== 20'h0 || reg_physical_page !== 8'h0 || fault_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_regs: vpn %h ppn %h cause %b, expected 0 0 00",
               reg_logic_page, reg_physical_page, fault_cause);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_fill();
    exp_t e;
    miss_valid = 1'b1;
    miss_vaddr = 32'h0040_3123;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0001_100C || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_req: mem_req %b addr %h busy %b, expected 1 0001100c 1", mem_req, mem_addr, busy);
    end
    miss_vaddr = 32'h1234_5678;
    mem_gnt    = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_req_drop: mem_req %b, expected 0", mem_req);
    end
    sb.push_back(model(32'h0040_3123, 32'h0000_2A03));
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_2A03;
    tick();
    mem_rvalid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (tlb_write !== 1'b1 || refill_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill_n3: write %b done %b, expected 1 1", tlb_write, refill_done);
    end
    checks++;
    if (reg_logic_page !== 20'h00403 || reg_physical_page !== 8'h2A || e.ppn !== 8'h2A) begin
      errors++;
      $display("FAIL basic_fill_data: vpn %h ppn %h, expected 00403 2a", reg_logic_page, reg_physical_page);
    end
    miss_valid = 1'b0;
    tick();
    checks++;
    if (tlb_write !== 1'b0 || refill_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: write %b done %b busy %b, expected 0 0 0", tlb_write, refill_done, busy);
    end
  endtask

  task automatic test_pte_faults();
    int rw;
    int w0;
    w0 = n_write;
    run_walk(32'h0040_3123, 32'h0000_2A00, 0, 0, rw);
    tick();
    checks++;
    if (fault_valid !== 1'b0 || fault_cause !== 2'b01) begin
      errors++;
      $display("FAIL fault_hold: fault_valid %b cause %b, expected 0 01", fault_valid, fault_cause);
    end
    run_walk(32'h0040_3123, 32'h0000_2A01, 1, 2, rw);
    tick();
    checks++;
    if (n_write != w0) begin
      errors++;
      $display("FAIL fault_no_write: %0d tlb_write pulses, expected 0", n_write - w0);
    end
  endtask

  task automatic test_timeout();
    int k;
    int w0;
    int f0;
    w0 = n_write;
    f0 = n_fault;
    miss_valid = 1'b1;
    miss_vaddr = 32'h0040_3123;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    k = 0;
    while (fault_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    miss_valid = 1'b0;
    checks++;
    if (k != TIMEOUT_TB || fault_cause !== 2'b11 || fault_vaddr !== 32'h0040_3123) begin
      errors++;
      $display("FAIL timeout_fault: after %0d cycles cause %b vaddr %h, expected %0d 11 00403123",
               k, fault_cause, fault_vaddr, TIMEOUT_TB);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_2A03;
    tick();
    mem_rvalid = 1'b0;
    repeat (3) tick();
    checks++;
    if (n_write != w0 || n_fault != f0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_rvalid: writes %0d faults %0d busy %b, expected 0 1 0",
               n_write - w0, n_fault - f0, busy);
    end
  endtask

  task automatic test_flush();
    int w0;
    int f0;
    w0 = n_write;
    f0 = n_fault;
    miss_valid = 1'b1;
    miss_vaddr = 32'h0000_5000;
    tick();
    flush      = 1'b1;
    mem_gnt    = 1'b1;
    miss_valid = 1'b0;
    tick();
    flush   = 1'b0;
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: mem_req %b busy %b, expected 0 0", mem_req, busy);
    end
    tick();
    miss_valid = 1'b1;
    miss_vaddr = 32'h0000_6000;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    flush      = 1'b1;
    miss_valid = 1'b0;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_drain_busy: busy %b, expected 1", busy);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_2A03;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain_exit: busy %b, expected 0", busy);
    end
    repeat (2) tick();
    checks++;
    if (n_write != w0 || n_fault != f0) begin
      errors++;
      $display("FAIL flush_no_pulses: writes %0d faults %0d, expected 0 0", n_write - w0, n_fault - f0);
    end
  endtask

  task automatic test_reset_mid_walk();
    int w0;
    int f0;
    w0 = n_write;
    f0 = n_fault;
    miss_valid = 1'b1;
    miss_vaddr = 32'h0040_3123;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, tlb_write, refill_done, fault_valid} !== 5'b0 || mem_addr !== 32'h0 ||
        reg_logic_page !== 20'h0 || fault_vaddr !== 32'h0 || fault_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: ctrl %b addr %h vpn %h, expected all 0",
               {mem_req, busy, tlb_write, refill_done, fault_valid}, mem_addr, reg_logic_page);
    end
    miss_valid = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_2A03;
    tick();
    mem_rvalid = 1'b0;
    repeat (2) tick();
    checks++;
    if (n_write != w0 || n_fault != f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulses: writes %0d faults %0d busy %b, expected 0 0 0",
               n_write - w0, n_fault - f0, busy);
    end
  endtask

  task automatic test_supervisor();
    int seen;
    seen = 0;
    supervisor_mode = 1'b1;
    miss_valid      = 1'b1;
    miss_vaddr      = 32'h0040_3123;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL supervisor_bypass: %0d active cycles, expected 0", seen);
    end
    miss_valid      = 1'b0;
    supervisor_mode = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va;
    logic [31:0] pte;
    int          rw;
    for (int i = 0; i < 8; i++) begin
      va  = $urandom;
      pte = {16'h0, 8'($urandom_range(0, 255)), 6'h0, 2'($urandom_range(0, 3))};
      run_walk(va, pte, $urandom_range(0, 3), $urandom_range(0, 3), rw);
      if (i > 0) begin
        checks++;
        if (rw != 1) begin
          errors++;
          $display("FAIL b2b_resample: mem_req after %0d extra cycles, expected 1", rw);
        end
      end
    end
    tick();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: %0d pending, busy %b, expected 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    reset           = 1'b0;
    flush           = 1'b0;
    supervisor_mode = 1'b0;
    miss_valid      = 1'b0;
    miss_vaddr      = '0;
    mem_gnt         = 1'b0;
    mem_rvalid      = 1'b0;
    mem_rdata       = '0;
    test_reset();
    test_basic_fill();
    test_pte_faults();
    test_timeout();
    test_flush();
    test_reset_mid_walk();
    test_supervisor();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itlb_refill_ctrl.md
ITLB_REFILL_CTRL -- requirements
Module: itlb_refill_ctrl

Interface
REQ-001 Parameter PTBR, 32'h0001_0000, page-table base byte address; word-aligned.
REQ-002 Parameter TIMEOUT, 64, max cycles from grant to mem_rvalid before a timeout fault; 2..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 flush  input  1  abort any walk in progress.
REQ-006 supervisor_mode  input  1  1 = translation bypassed; misses ignored.
REQ-007 miss_valid  input  1  iTLB reports miss for miss_vaddr; level, held by fetch until refill_done or fault_valid.
REQ-008 miss_vaddr  input  32  faulting fetch virtual address.
REQ-009 mem_req  output  1  page-table read request.
REQ-010 mem_addr  output  32  PTE address = PTBR + {miss_vaddr[31:12], 2'b00}.
REQ-011 mem_gnt  input  1  request accepted in the cycle mem_req=1 and mem_gnt=1.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rdata  input  32  PTE: [0] V, [1] X, [15:8] PPN; other bits ignored.
REQ-014 tlb_write  output  1  one-cycle iTLB fill strobe.
REQ-015 reg_logic_page  output  20  VPN to fill, miss_vaddr[31:12].
REQ-016 reg_physical_page  output  8  PPN to fill, mem_rdata[15:8].
REQ-017 refill_done  output  1  one-cycle pulse, same cycle as tlb_write.
REQ-018 busy  output  1  1 in every state except IDLE.
REQ-019 fault_valid  output  1  one-cycle instruction-page-fault pulse.
REQ-020 fault_cause  output  2  01 invalid PTE, 10 non-executable, 11 timeout; held until next fault.
REQ-021 fault_vaddr  output  32  latched miss_vaddr of faulting walk.

Function
REQ-022 States: IDLE, REQ, WAIT, WRITE, FAULT, DRAIN; all outputs registered (Moore).
REQ-023 IDLE: miss_valid=1, supervisor_mode=0, flush=0 -> latch miss_vaddr, go REQ; otherwise stay.
REQ-024 REQ: mem_req=1, mem_addr stable; mem_gnt=1 -> WAIT, timer cleared; flush=1 -> IDLE with no memory transaction (flush wins over mem_gnt same cycle, request treated as not issued).
REQ-025 WAIT: mem_rvalid=1 -> WRITE if V=1 and X=1; FAULT cause 01 if V=0; FAULT cause 10 if V=1, X=0.
REQ-026 WAIT: timer increments per cycle without mem_rvalid; timer reaching TIMEOUT -> FAULT cause 11.
REQ-027 WAIT with flush=1 -> DRAIN; DRAIN discards the one outstanding response, leaves on mem_rvalid or timeout -> IDLE; no tlb_write, no fault.
REQ-028 WRITE: tlb_write=1, refill_done=1 for exactly one cycle, reg_* valid that cycle -> IDLE.
REQ-029 FAULT: fault_valid=1 one cycle -> IDLE; flush in FAULT does not suppress the pulse.
REQ-030 Minimum latency: miss sampled cycle N -> mem_req N+1 -> (gnt N+1, rvalid N+2) -> tlb_write N+3.
REQ-031 At most one outstanding memory read; new misses while busy=1 ignored; miss_vaddr changes after latch ignored.
REQ-032 mem_addr wraps modulo 2^32.
REQ-033 Back-to-back: IDLE re-samples miss_valid the cycle after WRITE/FAULT; minimum 4 cycles per walk.

Reset
REQ-034 reset=0 forces IDLE immediately, mid-walk included; no tlb_write or fault generated for the aborted walk.
REQ-035 Reset values: mem_req, tlb_write, refill_done, busy, fault_valid = 0; mem_addr, reg_logic_page, reg_physical_page, fault_vaddr = 0; fault_cause = 00; timer = 0.

Structure
REQ-036 Shared package itlb_pkg holds state enum, PTE bit positions (V, X, PPN range), fault-cause constants.
REQ-037 Timeout counter SHALL be sub-module itlb_walk_timer (clear, enable, expired output).

Verification
REQ-038 Miss 0x0040_3123, PTBR default, gnt immediate, rdata 0x0000_2A03 -> mem_addr 0x0001_100C; tlb_write at N+3 with reg_logic_page 0x00403, reg_physical_page 0x2A.
REQ-039 rdata 0x0000_2A00 -> fault_valid one cycle, fault_cause 01, fault_vaddr 0x0040_3123; rdata 0x0000_2A01 -> cause 10; no tlb_write either case.
REQ-040 Grant, no rvalid for 64 cycles -> fault_cause 11 on expiry; late rvalid afterwards ignored in IDLE.
REQ-041 flush in REQ before gnt -> mem_req drops next cycle, busy 0; flush in WAIT then rvalid 5 cycles later -> DRAIN, busy 0 after rvalid, no tlb_write/fault.
REQ-042 reset asserted mid-WAIT asynchronously -> all outputs 0 before next edge; supervisor_mode=1 with miss_valid=1 -> mem_req stays 0.
